data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 105 ++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data RAM plus an MMIO output FIFO (FIFO_DATA/STATUS/CYCLE) behind a single processor port.
// Optional feature: define CYCLE_COUNTER_EN to add a free-running 32-bit cycle counter readable at CYCLE.
module data_mem_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int          RAM_AW         = $clog2(RAM_WORDS);
  localparam int          PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] RAM_LIMIT      = 32'(4 * RAM_WORDS);
  localparam logic [31:0] ADDR_FIFO_DATA = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS    = 32'h0000_1004;
  localparam logic [31:0] ADDR_CYCLE     = 32'h0000_1008;
  localparam logic [4:0]  DEPTH_CNT      = 5'(FIFO_DEPTH);

  logic [31:0]      ram      [RAM_WORDS];
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [4:0]       count;
  logic             overflow;
  logic [31:0]      cycle_rd;

  logic              ram_sel, fifo_sel, status_sel, cycle_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              full, empty, pop, push, drop, status_wr;
  logic [31:0]       status_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // RAM decode wins over MMIO so an oversized RAM can never alias a register.
  assign ram_sel    = (address_to_mem < RAM_LIMIT);
  assign ram_idx    = address_to_mem[RAM_AW+1:2];
  assign fifo_sel   = !ram_sel && (address_to_mem == ADDR_FIFO_DATA);
  assign status_sel = !ram_sel && (address_to_mem == ADDR_STATUS);
  assign cycle_sel  = !ram_sel && (address_to_mem == ADDR_CYCLE);

  assign empty     = (count == 5'd0);
  assign full      = (count == DEPTH_CNT);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = WE && fifo_sel && (!full || pop);
  assign drop      = WE && fifo_sel && full && !pop;
  assign status_wr = WE && status_sel;

  assign status_word = {21'd0, overflow, empty, full, 3'd0, count};
  assign out_data    = empty ? '0 : fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
      // A drop in the same cycle as a clear must leave the sticky flag set.
      if (drop)           overflow <= 1'b1;
      else if (status_wr) overflow <= 1'b0;
    end
  end

  // NOTE: storage arrays carry no reset; clearing them would need per-word reset muxes and
  // nothing depends on their contents until written (the FIFO head is masked while empty).
  always_ff @(posedge clk) begin
    if (WE && ram_sel) ram[ram_idx] <= data_to_mem;
    if (push)          fifo_mem[wr_ptr] <= data_to_mem;
  end

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_count <= '0;
    else        cycle_count <= cycle_count + 32'd1;
  end

  assign cycle_rd = cycle_count;
`else
  assign cycle_rd = '0;
`endif

  // NOTE: the default assignment first keeps this block purely combinational (no latch on any path).
  always_comb begin
    data_from_mem = '0;
    if (ram_sel)         data_from_mem = ram[ram_idx];
    else if (status_sel) data_from_mem = status_word;
    else if (cycle_sel)  data_from_mem = cycle_rd;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected read data and maintains a
// queue-level FIFO/RAM model; a negedge monitor pops and compares whatever the DUT presents.
module tb_data_mem_responder;

  localparam int          RAM_WORDS  = 256;
  localparam int          FIFO_DEPTH = 8;
  localparam int          POOL       = 16;
  localparam logic [31:0] FIFO_DATA  = 32'h0000_1000;
  localparam logic [31:0] STATUS     = 32'h0000_1004;
  localparam logic [31:0] CYCLE      = 32'h0000_1008;
`ifdef CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  data_mem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state (post-edge view).
  logic [31:0] fifo_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] ram_m[int];
  bit          ovf_m;
  int unsigned cyc_m;
  int unsigned pool[POOL];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned n;
    logic [31:0] s;
    n = fifo_q.size();
    if (a < 32'(4 * RAM_WORDS)) return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0;
    if (a == STATUS) begin
      s = n;
      if (n == FIFO_DEPTH) s = s + 32'h100;
      if (n == 0)          s = s + 32'h200;
      if (ovf_m)           s = s + 32'h400;
      return s;
    end
    if (a == CYCLE) return CYC_EN ? cyc_m : 32'h0;
    return 32'h0;
  endfunction

  // One bus cycle: drive, queue the expected read, then commit model effects at the edge.
  task automatic cycle(input logic we_i, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic chk = 1'b0,
                       input logic [31:0] chk_val = 32'h0, input string nm = "");
    int unsigned n;
    bit pop, is_fifo, accept, dropped, clr, ram_wr;
    WE = we_i; address_to_mem = a; data_to_mem = d; out_ready = rdy;
    rd_q.push_back(model_read(a));
    n       = fifo_q.size();
    pop     = reset && (n != 0) && rdy;
    is_fifo = we_i && (a == FIFO_DATA);
    accept  = is_fifo && ((n < FIFO_DEPTH) || pop);
    dropped = is_fifo && !accept;
    clr     = we_i && (a == STATUS);
    ram_wr  = we_i && (a < 32'(4 * RAM_WORDS));
    if (chk) begin
      #1;
      check(nm, data_from_mem, chk_val);
    end
    @(posedge clk);
    if (ram_wr) ram_m[int'(a >> 2)] = d;
    if (reset) begin
      if (accept) fifo_q.push_back(d);
      if (dropped)  ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      cyc_m++;
    end
    #1;
  endtask

  // Monitor: every negedge compare read data and the FIFO head against the scoreboard.
  always @(negedge clk) begin
    if (rd_q.size() != 0) check("rd_data", data_from_mem, rd_q.pop_front());
    check("out_valid", {31'd0, out_valid}, {31'd0, fifo_q.size() != 0});
    check("out_data", out_data, (fifo_q.size() != 0) ? fifo_q[0] : 32'h0);
    if (reset && out_ready && fifo_q.size() != 0) void'(fifo_q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int unsigned sel, rdy_pct;
    logic rdy;
    logic [31:0] unmapped[5];
    unmapped[0] = 32'h0000_0400; unmapped[1] = 32'h0000_1001; unmapped[2] = 32'h0000_100C;
    unmapped[3] = 32'hFFFF_FFFC; unmapped[4] = 32'h0000_0FFC;

    // Reset state.
    WE = 1'b0; address_to_mem = STATUS; data_to_mem = '0; out_ready = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_status", data_from_mem, 32'h0000_0200);
    ovf_m = 1'b0; cyc_m = 0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Cycle counter: 10 edges after release.
    for (int i = 0; i < 10; i++) cycle(1'b0, CYCLE, 32'h0, 1'b0);
    cycle(1'b0, CYCLE, 32'h0, 1'b0, 1'b1, CYC_EN ? 32'd10 : 32'd0, "cycle_after_10");

    // RAM write then read with low address bits set.
    cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 32'h0000_0012, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "ram_byte_offset");

    // Fill the RAM pool used by random traffic, including both region boundaries.
    pool[0] = 0; pool[1] = RAM_WORDS - 1;
    for (int i = 2; i < POOL; i++) pool[i] = $urandom_range(0, RAM_WORDS - 1);
    for (int i = 0; i < POOL; i++) cycle(1'b1, 32'(pool[i] << 2), $urandom, 1'b0);

    // Fill to full, then a dropped push sets overflow.
    for (int i = 1; i <= 8; i++) cycle(1'b1, FIFO_DATA, 32'(i), 1'b0);
    cycle(1'b0, STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0108, "status_full");
    cycle(1'b1, FIFO_DATA, 32'd9, 1'b0);
    cycle(1'b0, STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0508, "status_overflow");
    check("head_after_drop", out_data, 32'd1);
    cycle(1'b1, STATUS, 32'h0, 1'b0);
    cycle(1'b0, STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0108, "status_cleared");

    // Push while full with a simultaneous pop.
    cycle(1'b1, FIFO_DATA, 32'd9, 1'b1);
    check("head_after_push_pop", out_data, 32'd2);
    cycle(1'b0, STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0108, "status_push_pop");

    // Overflow again, clear, then drain in order.
    cycle(1'b1, FIFO_DATA, 32'd10, 1'b0);
    cycle(1'b0, STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0508, "status_overflow2");
    cycle(1'b1, STATUS, 32'h0, 1'b0);
    cycle(1'b0, STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0108, "status_cleared2");
    for (int i = 0; i < 8; i++) begin
      check("drain_order", out_data, 32'(i + 2));
      cycle(1'b0, FIFO_DATA, 32'h0, 1'b1, 1'b1, 32'h0, "fifo_data_reads_zero");
    end
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, STATUS, 32'h0, 1'b1, 1'b1, 32'h0000_0200, "status_drained");

    // Reset mid-drain with three entries queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, FIFO_DATA, 32'(100 + i), 1'b0);
    cycle(1'b0, FIFO_DATA, 32'h0, 1'b1);
    cycle(1'b0, FIFO_DATA, 32'h0, 1'b1);
    check("pre_reset_head", out_data, 32'd102);
    reset = 1'b0;
    fifo_q.delete(); ovf_m = 1'b0; cyc_m = 0;
    #1;
    check("reset_valid_now", {31'd0, out_valid}, 32'd0);
    check("reset_data_now", out_data, 32'd0);
    cycle(1'b1, FIFO_DATA, 32'd55, 1'b1);
    cycle(1'b0, STATUS, 32'h0, 1'b1, 1'b1, 32'h0000_0200, "status_in_reset");
    reset = 1'b1;
    cycle(1'b0, STATUS, 32'h0, 1'b1, 1'b1, 32'h0000_0200, "status_after_release");

    // Randomized traffic: low drain rate first to reach full/overflow, then high.
    for (int k = 0; k < 600; k++) begin
      rdy_pct = (k < 300) ? 20 : 70;
      rdy = ($urandom_range(0, 99) < rdy_pct);
      sel = $urandom_range(0, 99);
      d   = $urandom;
      if (sel < 40) begin
        a = 32'(pool[$urandom_range(0, POOL - 1)] << 2) | 32'($urandom_range(0, 3));
        cycle($urandom_range(0, 1) == 1, a, d, rdy);
      end else if (sel < 65) begin
        cycle(1'b1, FIFO_DATA, d, rdy);
      end else if (sel < 75) begin
        cycle($urandom_range(0, 3) == 0, STATUS, d, rdy);
      end else if (sel < 85) begin
        cycle($urandom_range(0, 1) == 1, CYCLE, d, rdy);
      end else begin
        cycle($urandom_range(0, 1) == 1, unmapped[$urandom_range(0, 4)], d, rdy);
      end
    end

    // Let the monitor consume the last queued read.
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
